// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, funct3 size codes,
// access-size decode, byte enables, alignment test and load extension.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Unsigned codes only size loads; a store with BU/HU falls back to a word store.
    function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
        size_e sz;
        sz = SZ_W;
        case (f3)
            FUNCT3_B:  sz = SZ_B;
            FUNCT3_H:  sz = SZ_H;
            FUNCT3_BU: sz = is_store ? SZ_W : SZ_B;
            FUNCT3_HU: sz = is_store ? SZ_W : SZ_H;
            default:   sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] byte_enables(input size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            FUNCT3_B:  r = {{24{b[7]}}, b};
            FUNCT3_H:  r = {{16{h[15]}}, h};
            FUNCT3_BU: r = {24'h0, b};
            FUNCT3_HU: r = {16'h0, h};
            default:   r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_array #(
    parameter int DEPTH = 16384,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata_q <= mem_q[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, completes it LATENCY cycles later.
// Defining DMEM_MISALIGN_CHECK_EN adds a misaligned flag and suppresses unaligned H/W accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 16384,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic              resp_valid,
    output logic [31:0]       dout,
    output logic              busy,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic              misaligned,
`endif
    output logic [1:0]        dbg_state
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic       CHECK_EN = 1'b1;
`else
    localparam logic       CHECK_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      din_q, din_d;
    logic             store_q, store_d;
    logic [31:0]      dout_q, dout_d;

    logic             accept;
    size_e            acc_size, resp_size;
    logic             acc_mis, resp_mis;
    logic [3:0]       ram_we;
    logic [31:0]      ram_wdata, ram_rdata, load_val;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready and at
    // least one of mem_read/mem_write are high; req_ready is high only in IDLE and never
    // depends on req_valid. resp_valid is a one-cycle pulse with no back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
            din_q   <= 32'h0;
            store_q <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            din_q   <= din_d;
            store_q <= store_d;
            dout_q  <= dout_d;
        end
    end

    // The access happens on the edge that enters RESP so the registered read lands in RESP.
    always_comb begin : next_state
        accept  = req_valid & req_ready & (mem_read | mem_write);
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        f3_d    = f3_q;
        din_d   = din_q;
        store_d = store_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = addr[IDX_W+1:2];
                    off_d   = addr[1:0];
                    f3_d    = funct3;
                    din_d   = din;
                    store_d = mem_write;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : ram_port
        acc_size = access_size(f3_d, store_d);
        acc_mis  = CHECK_EN & is_misaligned(acc_size, off_d);
        ram_we   = 4'b0000;
        if (state_d == ST_RESP && store_d && !acc_mis && !reset) begin
            ram_we = byte_enables(acc_size, off_d);
        end
        case (acc_size)
            SZ_B:    ram_wdata = {4{din_d[7:0]}};
            SZ_H:    ram_wdata = {2{din_d[15:0]}};
            default: ram_wdata = din_d;
        endcase
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_dmem_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (idx_d),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin : outputs
        req_ready  = (state_q == ST_IDLE);
        busy       = ~req_ready;
        resp_valid = (state_q == ST_RESP);
        dbg_state  = state_q;
        resp_size  = access_size(f3_q, store_q);
        resp_mis   = CHECK_EN & is_misaligned(resp_size, off_q);
        load_val   = resp_mis ? 32'h0 : extend_load(ram_rdata, f3_q, off_q);
        dout       = (resp_valid && !store_q) ? load_val : dout_q;
        dout_d     = dout;
`ifdef DMEM_MISALIGN_CHECK_EN
        misaligned = resp_valid & resp_mis;
`endif
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table of loads/stores, back-to-back, reset-abort and
// random traffic, all checked through an expected-response queue.
module tb_data_mem_responder;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 16384;
    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] din = 32'h0;
    logic        req_ready, resp_valid, busy;
    logic [31:0] dout;
    logic [1:0]  dbg_state;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    // {is_load, misaligned, dout}
    logic [33:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] last_dout = 32'h0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    data_mem_responder #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .din        (din),
        .resp_valid (resp_valid),
        .dout       (dout),
        .busy       (busy),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misaligned (misaligned),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / model ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d);
        logic [31:0] w;
        w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
        case (f3)
            3'b000:  w[8*a[1:0] +: 8] = d[7:0];
            3'b001:  if (a[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
            default: w = d;
        endcase
        model_mem[widx(a)] = w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_CHECK_EN
    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a, input logic wr);
        if (f3 == 3'b000 || (f3 == 3'b100 && !wr)) return 1'b0;
        if (f3 == 3'b001 || (f3 == 3'b101 && !wr)) return a[0];
        return a[1:0] != 2'b00;
    endfunction
`endif

    // Computes the expected response, pushes it, updates the model and drives one request.
    function automatic void expect_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d, input logic use_exp,
                                       input logic [31:0] exp);
        logic        mis;
        logic [31:0] e;
        mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = model_mis(f3, a, wr);
`endif
        if (wr) begin
            if (!mis) model_store(f3, a, d);
            e = last_dout;
        end else begin
            e = use_exp ? exp : (mis ? 32'h0 : model_load(f3, a));
            last_dout = e;
        end
        exp_q.push_back({~wr, mis, e});
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic use_exp, input logic [31:0] exp);
        int guard = 0;
        @(posedge clk); #1;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        expect_req(wr, f3, a, d, use_exp, exp);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; din = d;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'($urandom_range(0, 7)); addr = $urandom; din = $urandom;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check("resp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        int          a;
        if (!reset) begin
            if (req_valid && req_ready && (mem_read || mem_write)) acc_q.push_back(cyc + 1);
            if (resp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("resp_latency", 32'(cyc - a + 1), 32'(LATENCY));
                    check(e[33] ? "load_dout" : "store_dout_held", dout, e[31:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
                    check("misaligned", {31'h0, misaligned}, {31'h0, e[32]});
`endif
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int c0;

        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080AD});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h10, 32'hFFFF1234, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 32'h00000034});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h00000012});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h80AD1234});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h18, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h18, 32'h0, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'((DEPTH + 2) * 4), 32'h5A5A1234, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h5A5A1234});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h22, 32'hFFFFFFFF, 32'h0});
`ifdef DMEM_MISALIGN_CHECK_EN
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 32'h00000000});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D});
`else
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 32'h00001234});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hFFFFFFFF});
`endif

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_dout", dout, 32'h0);
        check("reset_state", 32'(dbg_state), 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("reset_misaligned", 32'(misaligned), 32'd0);
`endif

        foreach (vecs[i]) begin
            issue(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, 1'b1, vecs[i].exp);
            wait_done();
        end

        // Back-to-back: req_valid stays high across a store and the following load.
        @(posedge clk); #1;
        check("b2b_ready_idle", 32'(req_ready), 32'd1);
        expect_req(1'b1, 3'b010, 32'h40, 32'h13572468, 1'b0, 32'h0);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        funct3 = 3'b010; addr = 32'h40; din = 32'h13572468;
        @(posedge clk); #1;
        c0 = cyc;
        expect_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h0);
        mem_read = 1'b1; mem_write = 1'b0; din = 32'h0;
        for (int k = 1; k <= LATENCY; k++) begin
            check($sformatf("b2b_ready_c%0d", k), 32'(req_ready), 32'd0);
            check($sformatf("b2b_busy_c%0d", k), 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        check("b2b_ready_c5", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0;
        check("b2b_second_accept_spacing", 32'(cyc - c0), 32'(LATENCY + 1));
        check("b2b_busy_after_second", 32'(busy), 32'd1);
        wait_done();

        // Reset during WAIT discards a pending store.
        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h11112222, 1'b0, 32'h0);
        wait_done();
        @(posedge clk); #1;
        req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h20; din = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_write = 1'b0;
        check("abort_state_wait", 32'(dbg_state), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        last_dout = 32'h0;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dout", dout, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abort_no_resp_%0d", k), 32'(resp_valid), 32'd0);
        end
        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h11112222);
        wait_done();

        // Random traffic over a small, fully initialised window.
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 1'b1, 3'b010, 32'h100 + 32'(i * 4), $urandom, 1'b0, 32'h0);
            wait_done();
        end
        for (int i = 0; i < 24; i++) begin
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            case ($urandom_range(0, wr ? 2 : 4))
                0:       f3 = 3'b000;
                1:       f3 = 3'b001;
                2:       f3 = 3'b010;
                3:       f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            issue(~wr, wr, f3, a, $urandom, 1'b0, 32'h0);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
